// File: rtl/tile_result_collector.sv
// Collects ROW x COL partial tiles from the tile multiplier, sums them over the
// K_TILES reduction steps of one (i,j) output tile, then drains it row-major over valid/ready.
module tile_result_collector #(
  parameter int WIDTH   = 16,
  parameter int ROW     = 4,
  parameter int COL     = 4,
  parameter int K_TILES = 4,
  parameter int J_TILES = 4,
  parameter int ADDR_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tile_valid,
  input  logic [ROW*COL*WIDTH-1:0] tile_data,
  input  logic [7:0]               tile_i,
  input  logic [7:0]               tile_j,
  input  logic [7:0]               tile_k,
  output logic                     tile_ready,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [WIDTH-1:0]         wr_data,
  output logic                     busy,
  output logic                     seq_err,
  output logic                     ovf_err,
  output logic [15:0]              tiles_out
);

  localparam int NE = ROW * COL;
  localparam int NW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(NE - 1);
  localparam logic [7:0]    K_LAST = 8'(K_TILES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NE*WIDTH-1:0]     acc_q, acc_d, sum_s;
  logic [7:0]              exp_k_q, exp_k_d;
  logic [7:0]              cur_i_q, cur_i_d;
  logic [7:0]              cur_j_q, cur_j_d;
  logic [NW-1:0]           n_q, n_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]        wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    seq_err_q, seq_err_d;
  logic                    ovf_err_q, ovf_err_d;
  logic [15:0]             tiles_out_q, tiles_out_d;
  logic                    start_s;

  // Output-matrix address of element n of tile (i,j), row-major with stride J_TILES*COL.
  function automatic logic [ADDR_W-1:0] addr_f(input logic [7:0] i, input logic [7:0] j,
                                               input logic [NW-1:0] n);
    logic [31:0] r;
    logic [31:0] c;
    logic [31:0] a;
    r = 32'(n) / 32'(COL);
    c = 32'(n) % 32'(COL);
    a = (32'(i) * 32'(ROW) + r) * 32'(J_TILES * COL) + 32'(j) * 32'(COL) + c;
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] elem_f(input logic [NE*WIDTH-1:0] v, input logic [NW-1:0] n);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int e = 0; e < NE; e++) begin
      if (n == NW'(e)) begin
        res = v[e*WIDTH +: WIDTH];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Element-wise modulo-2^WIDTH sum of the accumulator and the incoming partial tile.
  always_comb begin
    sum_s = '0;
    for (int e = 0; e < NE; e++) begin
      sum_s[e*WIDTH +: WIDTH] = acc_q[e*WIDTH +: WIDTH] + tile_data[e*WIDTH +: WIDTH];
    end
  end

  assign tile_ready = (state_q != DRAIN);

  // Next-state and registered-output logic for accept, accumulate and drain.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    exp_k_d     = exp_k_q;
    cur_i_d     = cur_i_q;
    cur_j_d     = cur_j_q;
    n_d         = n_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    seq_err_d   = seq_err_q;
    ovf_err_d   = ovf_err_q;
    tiles_out_d = tiles_out_q;
    start_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tile_valid) begin
          if (tile_k == 8'd0) begin
            acc_d   = tile_data;
            cur_i_d = tile_i;
            cur_j_d = tile_j;
            exp_k_d = 8'd1;
            if (K_TILES == 1) begin
              state_d = DRAIN;
              start_s = 1'b1;
            end else begin
              state_d = ACC;
            end
          end else begin
            seq_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (tile_valid) begin
          if ((tile_i == cur_i_q) && (tile_j == cur_j_q) && (tile_k == exp_k_q)) begin
            acc_d   = sum_s;
            exp_k_d = exp_k_q + 8'd1;
            if (tile_k == K_LAST) begin
              state_d = DRAIN;
              start_s = 1'b1;
            end else begin
              state_d = ACC;
            end
          end else begin
            seq_err_d = 1'b1;
          end
        end else begin
          state_d = ACC;
        end
      end
      DRAIN: begin
        if (tile_valid) begin
          ovf_err_d = 1'b1;
        end else begin
          ovf_err_d = ovf_err_q;
        end
        if (wr_ready) begin
          if (n_q == N_LAST) begin
            wr_valid_d  = 1'b0;
            tiles_out_d = tiles_out_q + 16'd1;
            exp_k_d     = 8'd0;
            acc_d       = '0;
            n_d         = '0;
            state_d     = IDLE;
          end else begin
            n_d       = n_q + NW'(1);
            wr_addr_d = addr_f(cur_i_q, cur_j_q, n_q + NW'(1));
            wr_data_d = elem_f(acc_q, n_q + NW'(1));
          end
        end else begin
          n_d = n_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The first word goes out the cycle after the final accept.
    if (start_s) begin
      n_d        = '0;
      wr_valid_d = 1'b1;
      wr_addr_d  = addr_f(cur_i_d, cur_j_d, '0);
      wr_data_d  = elem_f(acc_d, '0);
    end else begin
      n_d = n_d;
    end

    busy_d = (state_d != IDLE);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      exp_k_q     <= 8'd0;
      cur_i_q     <= 8'd0;
      cur_j_q     <= 8'd0;
      n_q         <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      tiles_out_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      exp_k_q     <= exp_k_d;
      cur_i_q     <= cur_i_d;
      cur_j_q     <= cur_j_d;
      n_q         <= n_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      seq_err_q   <= seq_err_d;
      ovf_err_q   <= ovf_err_d;
      tiles_out_q <= tiles_out_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign seq_err   = seq_err_q;
  assign ovf_err   = ovf_err_q;
  assign tiles_out = tiles_out_q;

endmodule

// File: tb/tb_tile_result_collector.sv
// Directed bench for tile_result_collector: default instance (K=4, J=4) plus a
// K_TILES=1, J_TILES=1 instance for the single-step back-to-back case.
module tb_tile_result_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         tile_valid, tile_valid1;
  logic [255:0] tile_data;
  logic [7:0]   ti, tj, tk;
  logic         wr_ready, wr_ready1;

  logic         tile_ready, wr_valid, busy, seq_err, ovf_err;
  logic [9:0]   wr_addr;
  logic [15:0]  wr_data, tiles_out;
  logic         tile_ready1, wr_valid1, busy1, seq_err1, ovf_err1;
  logic [9:0]   wr_addr1;
  logic [15:0]  wr_data1, tiles_out1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tile_result_collector dut (
    .clk(clk), .rst(rst), .tile_valid(tile_valid), .tile_data(tile_data),
    .tile_i(ti), .tile_j(tj), .tile_k(tk), .tile_ready(tile_ready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .seq_err(seq_err), .ovf_err(ovf_err), .tiles_out(tiles_out)
  );

  tile_result_collector #(.K_TILES(1), .J_TILES(1)) dut1 (
    .clk(clk), .rst(rst), .tile_valid(tile_valid1), .tile_data(tile_data),
    .tile_i(ti), .tile_j(tj), .tile_k(tk), .tile_ready(tile_ready1),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .seq_err(seq_err1), .ovf_err(ovf_err1), .tiles_out(tiles_out1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] d;
    for (int e = 0; e < 16; e++) d[e*16 +: 16] = v;
    return d;
  endfunction

  task automatic send(input logic [7:0] i, input logic [7:0] j, input logic [7:0] k,
                      input logic [255:0] d);
    ti = i; tj = j; tk = k; tile_data = d;
    tile_valid = 1'b1;
    tick();
    tile_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Drains dut from element 'start' with wr_ready high; checks every word.
  task automatic drain(input string tag, input int i, input int j, input logic [255:0] exp_acc,
                       input int start);
    int a;
    int t;
    wr_ready = 1'b1;
    for (int n = start; n < 16; n++) begin
      t = 0;
      while (!wr_valid && t < 20) begin
        tick();
        t++;
      end
      check_val({tag, "_valid"}, {31'd0, wr_valid}, 32'd1);
      a = (i * 4 + n / 4) * 16 + j * 4 + n % 4;
      check_val($sformatf("%s_addr%0d", tag, n), {22'd0, wr_addr}, {22'd0, a[9:0]});
      check_val($sformatf("%s_data%0d", tag, n), {16'd0, wr_data}, {16'd0, exp_acc[n*16 +: 16]});
      tick();
    end
    check_val({tag, "_end_valid"}, {31'd0, wr_valid}, 32'd0);
    check_val({tag, "_end_ready"}, {31'd0, tile_ready}, 32'd1);
  endtask

  // Single-step instance: one accept then sixteen words at addresses 0..15.
  task automatic drain1(input string tag, input logic [255:0] d);
    int t;
    wr_ready1 = 1'b1;
    for (int n = 0; n < 16; n++) begin
      t = 0;
      while (!wr_valid1 && t < 20) begin
        tick();
        t++;
      end
      check_val({tag, "_valid"}, {31'd0, wr_valid1}, 32'd1);
      check_val($sformatf("%s_addr%0d", tag, n), {22'd0, wr_addr1}, n);
      check_val($sformatf("%s_data%0d", tag, n), {16'd0, wr_data1}, {16'd0, d[n*16 +: 16]});
      tick();
    end
    check_val({tag, "_end_valid"}, {31'd0, wr_valid1}, 32'd0);
  endtask

  initial begin
    logic [255:0] d0, d1, d2, exp_w;
    rst = 1'b0; tile_valid = 1'b0; tile_valid1 = 1'b0;
    wr_ready = 1'b0; wr_ready1 = 1'b0;
    ti = 8'd0; tj = 8'd0; tk = 8'd0; tile_data = '0;
    tick(); tick();

    // Reset state
    check_val("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check_val("rst_wr_addr", {22'd0, wr_addr}, 32'd0);
    check_val("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_errs", {30'd0, seq_err, ovf_err}, 32'd0);
    check_val("rst_tiles_out", {16'd0, tiles_out}, 32'd0);
    rst = 1'b1;
    tick();
    check_val("rst_tile_ready", {31'd0, tile_ready}, 32'd1);

    // Basic accumulate: 4 x 0x0003 at (1,2)
    for (int k = 0; k < 4; k++) begin
      send(8'd1, 8'd2, 8'(k), fill(16'h0003));
      if (k == 0) check_val("basic_busy", {31'd0, busy}, 32'd1);
    end
    check_val("basic_ready_low", {31'd0, tile_ready}, 32'd0);
    check_val("basic_first_addr", {22'd0, wr_addr}, 32'h048);
    check_val("basic_first_data", {16'd0, wr_data}, 32'h000C);
    drain("basic", 1, 2, fill(16'h000C), 0);
    check_val("basic_tiles_out", {16'd0, tiles_out}, 32'd1);
    check_val("basic_busy_end", {31'd0, busy}, 32'd0);

    // Wrap and backpressure at (0,0): element 0 = FFFF+2, element e = 4e
    for (int e = 0; e < 16; e++) begin
      d0[e*16 +: 16] = 16'(e);
      exp_w[e*16 +: 16] = 16'(4 * e);
    end
    d1 = d0; d2 = d0;
    d0[15:0] = 16'hFFFF; d1[15:0] = 16'h0002; d2[15:0] = 16'h0000;
    exp_w[15:0] = 16'h0001;
    wr_ready = 1'b0;
    send(8'd0, 8'd0, 8'd0, d0);
    send(8'd0, 8'd0, 8'd1, d1);
    send(8'd0, 8'd0, 8'd2, d2);
    send(8'd0, 8'd0, 8'd3, d2);
    for (int h = 0; h < 3; h++) begin
      check_val($sformatf("wrap_hold_data%0d", h), {16'd0, wr_data}, 32'h0001);
      check_val($sformatf("wrap_hold_addr%0d", h), {22'd0, wr_addr}, 32'd0);
      check_val($sformatf("wrap_hold_valid%0d", h), {31'd0, wr_valid}, 32'd1);
      if (h < 2) tick();
    end
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    check_val("wrap_next_data", {16'd0, wr_data}, 32'h0004);
    tick();
    check_val("wrap_stall_addr", {22'd0, wr_addr}, 32'd1);
    drain("wrap", 0, 0, exp_w, 1);
    check_val("wrap_tiles_out", {16'd0, tiles_out}, 32'd2);

    // Sequence error in ACC: k=0, bad k=2, then k=1..3 -> 5+1+1+1
    send(8'd2, 8'd1, 8'd0, fill(16'h0005));
    send(8'd2, 8'd1, 8'd2, fill(16'h0007));
    check_val("seq_acc_err", {31'd0, seq_err}, 32'd1);
    check_val("seq_acc_ready", {31'd0, tile_ready}, 32'd1);
    send(8'd2, 8'd1, 8'd1, fill(16'h0001));
    send(8'd2, 8'd1, 8'd2, fill(16'h0001));
    send(8'd2, 8'd1, 8'd3, fill(16'h0001));
    drain("seq", 2, 1, fill(16'h0008), 0);
    check_val("seq_sticky", {31'd0, seq_err}, 32'd1);

    // Sequence error in IDLE: k=1 dropped
    pulse_reset();
    check_val("seq_cleared", {31'd0, seq_err}, 32'd0);
    send(8'd0, 8'd0, 8'd1, fill(16'h0009));
    check_val("seq_idle_err", {31'd0, seq_err}, 32'd1);
    check_val("seq_idle_busy", {31'd0, busy}, 32'd0);

    // Overflow during drain at (3,3)
    wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(8'd3, 8'd3, 8'(k), fill(16'h0001));
    send(8'd3, 8'd3, 8'd0, fill(16'h0100));
    check_val("ovf_flag", {31'd0, ovf_err}, 32'd1);
    drain("ovf", 3, 3, fill(16'h0004), 0);
    check_val("ovf_tiles_out", {16'd0, tiles_out}, 32'd1);

    // Reset during element 5 of a drain at (1,1)
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(8'd1, 8'd1, 8'(k), fill(16'h0002));
    for (int n = 0; n < 5; n++) tick();
    check_val("mid_addr5", {22'd0, wr_addr}, 32'h055);
    check_val("mid_valid5", {31'd0, wr_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'd0, wr_valid}, 32'd0);
    check_val("mid_rst_flags", {29'd0, busy, seq_err, ovf_err}, 32'd0);
    check_val("mid_rst_tiles", {16'd0, tiles_out}, 32'd0);
    wr_ready = 1'b0;
    rst = 1'b1;
    tick();
    check_val("mid_rel_ready", {31'd0, tile_ready}, 32'd1);
    check_val("mid_rel_valid", {31'd0, wr_valid}, 32'd0);

    // K_TILES=1, J_TILES=1: two back-to-back tiles
    for (int e = 0; e < 16; e++) begin
      d0[e*16 +: 16] = 16'h0100 + 16'(e);
      d1[e*16 +: 16] = 16'hA000 + 16'(e);
    end
    ti = 8'd0; tj = 8'd0; tk = 8'd0; tile_data = d0;
    tile_valid1 = 1'b1; tick(); tile_valid1 = 1'b0;
    drain1("k1a", d0);
    tile_data = d1;
    tile_valid1 = 1'b1; tick(); tile_valid1 = 1'b0;
    check_val("k1b_accept", {31'd0, wr_valid1}, 32'd1);
    drain1("k1b", d1);
    check_val("k1_tiles_out", {16'd0, tiles_out1}, 32'd2);
    check_val("k1_errs", {30'd0, seq_err1, ovf_err1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
